// File: rtl/skip_count_ctrl.sv
// skip_count_ctrl
//   Sequencer/controller for a modulo-N up-counter that skips one selectable
//   value. Configuration is taken through a valid/ready handshake in IDLE;
//   the counter runs, pauses, stops, and ends after a programmed number of
//   wrap-arounds. All outputs are registered.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active-low
//   cfg_valid    configuration offer
//   cfg_ready    high in IDLE; handshake when high together with cfg_valid
//   cfg_mod      modulus (legal 2..2^WIDTH-1)
//   cfg_skip     value to skip
//   cfg_skip_en  enable skipping
//   cfg_wraps    wraps before done, 0 = run forever
//   cfg_err      one-cycle pulse when an offered config is rejected
//   start        begin counting (IDLE only)
//   pause        level, freeze while high
//   stop         abort to IDLE
//   count        current count
//   count_valid  high in RUN and HOLD
//   wrap         one-cycle pulse when count returns to 0
//   done         one-cycle pulse when the wrap limit is reached
//   busy         high in RUN, HOLD, DONE
module skip_count_ctrl #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned DEF_MOD  = 7,
    parameter int unsigned DEF_SKIP = 3,
    parameter int unsigned WRAP_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [WIDTH-1:0]  cfg_mod,
    input  logic [WIDTH-1:0]  cfg_skip,
    input  logic              cfg_skip_en,
    input  logic [WRAP_W-1:0] cfg_wraps,
    output logic              cfg_err,
    input  logic              start,
    input  logic              pause,
    input  logic              stop,
    output logic [WIDTH-1:0]  count,
    output logic              count_valid,
    output logic              wrap,
    output logic              done,
    output logic              busy
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_t;

    state_t            state, state_nx;
    logic [WIDTH-1:0]  mod_r, skip_r;
    logic              skip_en_r;
    logic [WRAP_W-1:0] wraps_r, wcnt;

    logic [WIDTH-1:0]  mod_nx, skip_nx, count_nx;
    logic              skip_en_nx;
    logic [WRAP_W-1:0] wraps_nx, wcnt_nx;
    logic              err_nx, wrap_nx, done_nx;

    logic              cfg_hs, cfg_legal, cfg_bad;
    logic [WIDTH:0]    adv;
    logic              adv_wrap;
    logic [WRAP_W-1:0] wcnt_inc;
    logic              limit_hit;

    // Datapath helpers shared by next-state and output logic.
    // adv is one bit wider so that count+1 (and +2 past the skip) cannot
    // alias back into range before the modulus compare.
    always_comb begin
        cfg_hs    = cfg_valid && (state == S_IDLE);
        cfg_legal = ({1'b0, cfg_mod} >= (WIDTH+1)'(2));
        if (cfg_skip_en) begin
            cfg_legal = cfg_legal
                     && ({1'b0, cfg_mod} >= (WIDTH+1)'(3))
                     && (cfg_skip != '0)
                     && (cfg_skip < cfg_mod);
        end
        cfg_bad = cfg_hs && !cfg_legal;

        adv = {1'b0, count} + (WIDTH+1)'(1);
        if (skip_en_r && (adv == {1'b0, skip_r})) begin
            adv = adv + (WIDTH+1)'(1);
        end
        adv_wrap = (adv >= {1'b0, mod_r});

        // Saturating increment keeps an unlimited run from rolling over.
        wcnt_inc  = (wcnt == '1) ? wcnt : wcnt + WRAP_W'(1);
        limit_hit = (wraps_r != '0) && (wcnt_inc == wraps_r);
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start && !cfg_bad) state_nx = S_RUN;
            S_RUN: begin
                if (stop)                        state_nx = S_IDLE;
                else if (pause)                  state_nx = S_HOLD;
                else if (adv_wrap && limit_hit)  state_nx = S_DONE;
            end
            S_HOLD: begin
                if (stop)        state_nx = S_IDLE;
                else if (!pause) state_nx = S_RUN;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        count_nx   = count;
        mod_nx     = mod_r;
        skip_nx    = skip_r;
        skip_en_nx = skip_en_r;
        wraps_nx   = wraps_r;
        wcnt_nx    = wcnt;
        err_nx     = 1'b0;
        wrap_nx    = 1'b0;
        done_nx    = 1'b0;
        case (state)
            S_IDLE: begin
                count_nx = '0;
                err_nx   = cfg_bad;
                if (cfg_hs && cfg_legal) begin
                    mod_nx     = cfg_mod;
                    skip_nx    = cfg_skip;
                    skip_en_nx = cfg_skip_en;
                    wraps_nx   = cfg_wraps;
                end
                if (start && !cfg_bad) wcnt_nx = '0;
            end
            S_RUN: begin
                if (stop) begin
                    count_nx = '0;
                end else if (!pause) begin
                    count_nx = adv_wrap ? '0 : adv[WIDTH-1:0];
                    if (adv_wrap) begin
                        wrap_nx = 1'b1;
                        wcnt_nx = wcnt_inc;
                        done_nx = limit_hit;
                    end
                end
            end
            S_HOLD: if (stop) count_nx = '0;
            S_DONE: count_nx = '0;
            default: count_nx = '0;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            count       <= '0;
            mod_r       <= WIDTH'(DEF_MOD);
            skip_r      <= WIDTH'(DEF_SKIP);
            skip_en_r   <= 1'b1;
            wraps_r     <= '0;
            wcnt        <= '0;
            cfg_ready   <= 1'b1;
            cfg_err     <= 1'b0;
            count_valid <= 1'b0;
            wrap        <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            count       <= count_nx;
            mod_r       <= mod_nx;
            skip_r      <= skip_nx;
            skip_en_r   <= skip_en_nx;
            wraps_r     <= wraps_nx;
            wcnt        <= wcnt_nx;
            cfg_ready   <= (state_nx == S_IDLE);
            cfg_err     <= err_nx;
            count_valid <= (state_nx == S_RUN) || (state_nx == S_HOLD);
            wrap        <= wrap_nx;
            done        <= done_nx;
            busy        <= (state_nx != S_IDLE);
        end
    end

endmodule

// File: doc/skip_count_ctrl.md
Name: skip_count_ctrl

Overview:
Programmable sequencer and controller for a modulo-N up-counter that skips one selectable value. It holds the modulus and skip configuration, accepted through a valid/ready handshake. It starts, pauses, stops and terminates the count after a programmed number of wrap-arounds, and emits wrap and done pulses to downstream logic. The counter datapath is contained in this block.

Parameters:
WIDTH, 4, width of count and of modulus/skip configuration
DEF_MOD, 7, modulus loaded at reset (count range 0..DEF_MOD-1)
DEF_SKIP, 3, skip value loaded at reset (skip enabled at reset)
WRAP_W, 8, width of wrap-limit field

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-low
cfg_valid  input  1  configuration offer
cfg_ready  output  1  configuration accepted when high with cfg_valid
cfg_mod  input  WIDTH  modulus, legal 2..2^WIDTH-1
cfg_skip  input  WIDTH  value to skip
cfg_skip_en  input  1  enable skipping
cfg_wraps  input  WRAP_W  wraps before done; 0 = run forever
cfg_err  output  1  one-cycle pulse: offered config rejected
start  input  1  begin counting (IDLE only)
pause  input  1  level: freeze while high
stop  input  1  abort to IDLE
count  output  WIDTH  current count
count_valid  output  1  high in RUN and HOLD
wrap  output  1  one-cycle pulse on wrap to 0
done  output  1  one-cycle pulse on wrap-limit reached
busy  output  1  high in RUN, HOLD, DONE

Behaviour:
- rst low at a clk edge: state IDLE; count=0; mod=DEF_MOD, skip=DEF_SKIP, skip_en=1, wraps=0; wrap counter=0; cfg_ready=1; cfg_err, count_valid, wrap, done, busy all 0. rst has priority over everything.
- States: IDLE, RUN, HOLD, DONE. All outputs are registered.
- Config:
  - cfg_ready=1 only in IDLE. A handshake occurs when cfg_valid and cfg_ready are both high.
  - Legal config: cfg_mod>=2. If cfg_skip_en=1, additionally cfg_mod>=3 and 1<=cfg_skip<=cfg_mod-1.
  - Illegal config: registers unchanged, cfg_err=1 the next cycle.
  - cfg_valid outside IDLE is ignored; no cfg_err is raised.
- IDLE: start=1 -> RUN next cycle, count=0, wrap counter cleared.
  - start with an accepted legal cfg in the same cycle: the run uses the new config.
  - start with an illegal cfg in the same cycle: start is suppressed and the block stays in IDLE.
- RUN, each cycle, priority stop > pause > advance:
  - stop: next state IDLE, count=0, no done, no wrap.
  - pause (and no stop): next state HOLD, count frozen.
  - advance: n=count+1 computed in WIDTH+1 bits; if skip_en and n==skip, n=n+1; if n>=mod, n=0 and this is a wrap.
  - skip==mod-1: the wrap goes 0..mod-2 -> 0.
- Wrap:
  - wrap=1 in the cycle count first shows 0 after a wrap; the wrap counter increments.
  - If wraps!=0 and the incremented wrap counter equals wraps: the state goes to DONE instead of staying in RUN. count=0, wrap=1 and done=1 in that cycle, count_valid=0.
  - The wrap counter saturates (no overflow) when wraps=0.
- HOLD: stop -> IDLE with count=0; pause=0 -> RUN, advancing resumes the next cycle; otherwise stay. count_valid stays 1.
- DONE: lasts one cycle, then IDLE. stop and start are ignored in DONE.
- start is ignored in RUN and HOLD. pause and stop are ignored in IDLE.

Test Plan:
- Reset defaults, start pulse, wraps=0 -> count_valid rises; count runs 0,1,2,4,5,6,0,1,...; wrap pulses every 6 cycles when count returns to 0; done never asserts.
- Config mod=5, skip_en=0, wraps=2, then start -> count 0,1,2,3,4,0,1,2,3,4; next cycle DONE with wrap=1, done=1, count=0; then IDLE with cfg_ready=1.
- Config mod=7, skip=6, wraps=1 -> count 0,1,2,3,4,5; then done=1; 6 never appears.
- Illegal configs: mod=1; mod=6 with skip=0; mod=6 with skip=6 (skip_en=1) -> cfg_err one cycle each, prior config kept. An illegal cfg with start in the same cycle -> stays IDLE.
- Pause for 3 cycles at count=4, then release -> count holds at 4, count_valid=1; resumes at 5. Stop while in HOLD -> IDLE, count=0, done=0.
- rst low while in RUN at count=5 -> next cycle everything at reset values. cfg_valid driven in RUN -> cfg_ready=0, config unchanged.
